rgb565_axis_upsizer: RTL

Pack the 64-bit RGB565 stream from the 888-to-565 converter into 128-bit beats for the S2MM DMA. Each output beat holds two input beats (8 pixels) and is fully registered. Packets with an odd beat count are closed with a half-filled, tkeep-masked beat. The block also counts completed packets and flags malformed input tkeep.

---
 rtl/rgb565_stream_pkg.sv | 24 ++
 rtl/rgb565_axis_upsizer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rgb565_stream_pkg.sv
// Shared widths, keep constants and state type for the RGB565 stream blocks.
package rgb565_stream_pkg;

  localparam int PIX_W   = 16;
  localparam int IN_PIX  = 4;
  localparam int OUT_PIX = 8;
  localparam int IN_W    = PIX_W * IN_PIX;
  localparam int OUT_W   = PIX_W * OUT_PIX;

  localparam logic [15:0] KEEP_FULL    = 16'hFFFF;
  localparam logic [15:0] KEEP_HALF    = 16'h00FF;
  localparam logic [7:0]  KEEP_IN_FULL = 8'hFF;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } upsz_state_t;

  // Input beats must carry all eight bytes; anything else is malformed.
  function automatic logic keep_bad(input logic [7:0] keep);
    return (keep != KEEP_IN_FULL);
  endfunction

endpackage

// File: rtl/rgb565_axis_upsizer.sv
// Packs pairs of 64-bit RGB565 beats into registered 128-bit beats; odd packets
// close with a half beat padded by PAD_DATA.
module rgb565_axis_upsizer
  import rgb565_stream_pkg::*;
#(
  parameter logic [63:0] PAD_DATA = 64'h0
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         s_tlast,
  input  logic [7:0]   s_tkeep,
  input  logic [7:0]   s_tstrb,
  input  logic [63:0]  s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic [15:0]  m_tkeep,
  output logic [15:0]  m_tstrb,
  output logic [127:0] m_tdata,
  output logic [31:0]  pkt_count,
  output logic         err_keep
);

  upsz_state_t  state_q, state_d;
  logic [63:0]  lo_q, lo_d;
  logic         m_tvalid_q, m_tvalid_d;
  logic         m_tlast_q, m_tlast_d;
  logic [15:0]  m_tkeep_q, m_tkeep_d;
  logic [127:0] m_tdata_q, m_tdata_d;
  logic [31:0]  pkt_count_q, pkt_count_d;
  logic         err_keep_q, err_keep_d;

  logic         accept_s;
  logic         drain_s;
  logic         load_s;
  logic [127:0] word_data_s;
  logic [15:0]  word_keep_s;
  logic         word_last_s;
  logic         unused_tstrb_s;

  // Ready only looks at the output register, so a stalled beat blocks both states.
  assign s_tready       = aresetn & (~m_tvalid_q | m_tready);
  assign accept_s       = s_tvalid & s_tready;
  assign drain_s        = m_tvalid_q & m_tready;
  assign unused_tstrb_s = ^s_tstrb;

  // Pairing state machine: decides when an accepted beat completes a word.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    load_s      = 1'b0;
    word_data_s = 128'h0;
    word_keep_s = 16'h0;
    word_last_s = 1'b0;
    case (state_q)
      LOW: begin
        if (accept_s && s_tlast) begin
          load_s      = 1'b1;
          word_data_s = {PAD_DATA, s_tdata};
          word_keep_s = KEEP_HALF;
          word_last_s = 1'b1;
        end else if (accept_s) begin
          lo_d    = s_tdata;
          state_d = HIGH;
        end else begin
          state_d = LOW;
        end
      end
      HIGH: begin
        if (accept_s) begin
          load_s      = 1'b1;
          word_data_s = {s_tdata, lo_q};
          word_keep_s = KEEP_FULL;
          word_last_s = s_tlast;
          state_d     = LOW;
        end else begin
          state_d = HIGH;
        end
      end
      default: begin
        state_d = LOW;
      end
    endcase
  end

  // Output register: a new word wins over a drain, so load+drain keeps valid high.
  always_comb begin
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tkeep_d   = m_tkeep_q;
    m_tdata_d   = m_tdata_q;
    if (load_s) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = word_last_s;
      m_tkeep_d  = word_keep_s;
      m_tdata_d  = word_data_s;
    end else if (drain_s) begin
      m_tvalid_d = 1'b0;
    end else begin
      m_tvalid_d = m_tvalid_q;
    end
    pkt_count_d = pkt_count_q + {31'd0, drain_s & m_tlast_q};
    err_keep_d  = err_keep_q | (accept_s & keep_bad(s_tkeep));
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= LOW;
      lo_q        <= 64'h0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tkeep_q   <= 16'h0;
      m_tdata_q   <= 128'h0;
      pkt_count_q <= 32'h0;
      err_keep_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tdata_q   <= m_tdata_d;
      pkt_count_q <= pkt_count_d;
      err_keep_q  <= err_keep_d;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tkeep   = m_tkeep_q;
  assign m_tstrb   = m_tkeep_q;
  assign m_tdata   = m_tdata_q;
  assign pkt_count = pkt_count_q;
  assign err_keep  = err_keep_q;

endmodule
